// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, collapses each
// four-column frame to NONE / SINGLE(k) / MULTI, debounces across frames, reports keys.
module keypad_scanner #(
  parameter int unsigned SCAN_TICK       = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi
);

  localparam int unsigned CW = $clog2(SCAN_TICK);

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;
  typedef enum logic {IDLE, PRESSED} state_e;

  logic [3:0]    row_meta_q, row_s_q;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    cs_q, cs_d;
  logic [15:0]   frame_q, frame_d, frame_full;
  cls_e          prev_cls_q, prev_cls_d, cur_cls;
  logic [3:0]    prev_k_q, prev_k_d, cur_k;
  logic [7:0]    stab_q, stab_d;
  state_e        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d, held_q, held_d, multi_q, multi_d;
  logic [4:0]    ones;
  logic          tick, frame_end, stable;

  assign tick      = (count_q == CW'(SCAN_TICK - 1));
  assign frame_end = tick && (cs_q == 2'd3);
  assign col       = ~(4'b0001 << cs_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign multi     = multi_q;

  // The current column is merged in combinationally so the frame-end tick sees all 16 bits.
  always_comb begin
    frame_full = frame_q;
    frame_full[{cs_q, 2'b00} +: 4] = ~row_s_q;
    ones  = '0;
    cur_k = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (frame_full[i]) begin
        if (ones == 5'd0) cur_k = 4'(i);
        ones = ones + 5'd1;
      end
    end
    if (ones == 5'd0)      cur_cls = CLS_NONE;
    else if (ones == 5'd1) cur_cls = CLS_SINGLE;
    else                   cur_cls = CLS_MULTI;
    if (cur_cls != CLS_SINGLE) cur_k = '0;
  end

  always_comb begin
    count_d    = tick ? '0 : count_q + CW'(1);
    cs_d       = cs_q;
    frame_d    = frame_q;
    prev_cls_d = prev_cls_q;
    prev_k_d   = prev_k_q;
    stab_d     = stab_q;
    state_d    = state_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    multi_d    = multi_q;
    stable     = 1'b0;
    if (tick) begin
      cs_d    = cs_q + 2'd1;
      frame_d = frame_full;
    end
    if (frame_end) begin
      if ((cur_cls == prev_cls_q) && (cur_k == prev_k_q))
        stab_d = (stab_q < 8'(DEBOUNCE_FRAMES)) ? stab_q + 8'd1 : stab_q;
      else
        stab_d = 8'd1;
      prev_cls_d = cur_cls;
      prev_k_d   = cur_k;
      stable     = (stab_d == 8'(DEBOUNCE_FRAMES));
      multi_d    = stable && (cur_cls == CLS_MULTI);
      case (state_q)
        IDLE: begin
          if (stable && (cur_cls == CLS_SINGLE)) begin
            code_d  = cur_k;
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = PRESSED;
          end
        end
        PRESSED: begin
          if (stable && (cur_cls == CLS_NONE)) begin
            held_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= '1;
      row_s_q    <= '1;
      count_q    <= '0;
      cs_q       <= '0;
      frame_q    <= '0;
      prev_cls_q <= CLS_NONE;
      prev_k_q   <= '0;
      stab_q     <= '0;
      state_q    <= IDLE;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
      count_q    <= count_d;
      cs_q       <= cs_d;
      frame_q    <= frame_d;
      prev_cls_q <= prev_cls_d;
      prev_k_q   <= prev_k_d;
      stab_q     <= stab_d;
      state_q    <= state_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      multi_q    <= multi_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a per-frame table of hand-derived expectations, a
// reset-mid-press sequence, and random key patterns against a frame-history model.
module tb_keypad_scanner;

  localparam int unsigned ST = 4;
  localparam int unsigned DF = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held, multi;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] keys;
    logic        v;
    logic [3:0]  code;
    logic        held;
    logic        multi;
  } vec_t;
  vec_t tbl[$];

  // Reference model state: classification per frame since reset (-1 none, 0..15 key, 16 multi).
  int   hist[$];
  logic m_pressed;
  logic [3:0] m_code;

  keypad_scanner #(.SCAN_TICK(ST), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .multi(multi)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [15:0] m, input logic v, input logic [3:0] c,
                     input logic h, input logic mu);
    vec_t t;
    t.keys = m; t.v = v; t.code = c; t.held = h; t.multi = mu;
    tbl.push_back(t);
  endtask

  // One 16-cycle frame starting just after a frame-end edge; checks at its own frame end.
  task automatic run_frame(input logic [15:0] m, input logic ev, input logic [3:0] ec,
                           input logic eh, input logic em, input string tag);
    int col_bad = 0;
    int stray = 0;
    logic [3:0] exp_col;
    keys = m;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk); #1;
      exp_col = ~(4'b0001 << ((j / 4) % 4));
      if (col !== exp_col) col_bad++;
      if (j < 16 && key_valid !== 1'b0) stray++;
    end
    check({tag, ".col_errs"}, col_bad, 0);
    check({tag, ".stray_valid"}, stray, 0);
    check({tag, ".valid"}, key_valid, ev);
    check({tag, ".code"}, key_code, ec);
    check({tag, ".held"}, key_held, eh);
    check({tag, ".multi"}, multi, em);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check("rst.col", col, 4'b1110);
    check("rst.code", key_code, 4'h0);
    check("rst.valid", key_valid, 1'b0);
    check("rst.held", key_held, 1'b0);
    check("rst.multi", multi, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic model_frame(input logic [15:0] m, output logic v, output logic [3:0] c,
                             output logic h, output logic mu);
    int cls, n;
    logic stable;
    n = $countones(m);
    cls = (n == 0) ? -1 : 16;
    if (n == 1)
      for (int i = 0; i < 16; i++) if (m[i]) cls = i;
    hist.push_back(cls);
    if (hist.size() > DF) void'(hist.pop_front());
    stable = (hist.size() == DF);
    foreach (hist[i]) if (hist[i] != cls) stable = 1'b0;
    v = 1'b0;
    if (!m_pressed && stable && cls >= 0 && cls < 16) begin
      v = 1'b1; m_pressed = 1'b1; m_code = 4'(cls);
    end else if (m_pressed && stable && cls == -1) begin
      m_pressed = 1'b0;
    end
    c = m_code; h = m_pressed; mu = stable && (cls == 16);
  endtask

  initial begin
    logic [15:0] m;
    logic ev, eh, em;
    logic [3:0] ec;
    int a, b, r;

    // idle
    repeat (4) add(16'h0000, 0, 4'h0, 0, 0);
    // key 9 (column 2, row 1)
    add(16'h0200, 0, 4'h0, 0, 0); add(16'h0200, 0, 4'h0, 0, 0);
    add(16'h0200, 1, 4'h9, 1, 0); add(16'h0200, 0, 4'h9, 1, 0);
    // release
    add(16'h0000, 0, 4'h9, 1, 0); add(16'h0000, 0, 4'h9, 1, 0);
    add(16'h0000, 0, 4'h9, 0, 0);
    // bounce on key 0
    add(16'h0001, 0, 4'h9, 0, 0); add(16'h0001, 0, 4'h9, 0, 0);
    add(16'h0000, 0, 4'h9, 0, 0); add(16'h0001, 0, 4'h9, 0, 0);
    add(16'h0001, 0, 4'h9, 0, 0); add(16'h0001, 1, 4'h0, 1, 0);
    add(16'h0000, 0, 4'h0, 1, 0); add(16'h0000, 0, 4'h0, 1, 0);
    add(16'h0000, 0, 4'h0, 0, 0);
    // keys 3 and 12 together, then 12 dropped
    add(16'h1008, 0, 4'h0, 0, 0); add(16'h1008, 0, 4'h0, 0, 0);
    add(16'h1008, 0, 4'h0, 0, 1); add(16'h1008, 0, 4'h0, 0, 1);
    add(16'h0008, 0, 4'h0, 0, 0); add(16'h0008, 0, 4'h0, 0, 0);
    add(16'h0008, 1, 4'h3, 1, 0);
    // release, then press key 5
    add(16'h0000, 0, 4'h3, 1, 0); add(16'h0000, 0, 4'h3, 1, 0);
    add(16'h0000, 0, 4'h3, 0, 0);
    add(16'h0020, 0, 4'h3, 0, 0); add(16'h0020, 0, 4'h3, 0, 0);
    add(16'h0020, 1, 4'h5, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("init.col", col, 4'b1110);
    check("init.code", key_code, 4'h0);
    check("init.valid", key_valid, 1'b0);
    check("init.held", key_held, 1'b0);
    check("init.multi", multi, 1'b0);
    @(negedge clk) reset = 1'b1;

    foreach (tbl[i])
      run_frame(tbl[i].keys, tbl[i].v, tbl[i].code, tbl[i].held, tbl[i].multi,
                $sformatf("vec%0d", i));

    // Reset mid-frame while key 5 stays pressed; it must be re-debounced from scratch.
    repeat (6) @(posedge clk);
    pulse_reset();
    run_frame(16'h0020, 0, 4'h0, 0, 0, "rstkey.f1");
    run_frame(16'h0020, 0, 4'h0, 0, 0, "rstkey.f2");
    run_frame(16'h0020, 1, 4'h5, 1, 0, "rstkey.f3");

    // Random key patterns against the model.
    keys = '0;
    @(posedge clk);
    pulse_reset();
    hist.delete(); m_pressed = 1'b0; m_code = '0;
    m = '0;
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 9);
      if (r < 5) m = m;
      else if (r < 7) m = '0;
      else if (r < 9) m = 16'(1) << $urandom_range(0, 15);
      else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        m = (16'(1) << a) | (16'(1) << b);
      end
      model_frame(m, ev, ec, eh, em);
      run_frame(m, ev, ec, eh, em, $sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
